cond_check_unit: RTL and testbench
==================================

COND_CHECK_UNIT -- requirements
Module: cond_check_unit

Interface
REQ-001 SHALL: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: req_valid  input  1  condition-check request present.
REQ-004 SHALL: req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-005 SHALL: cond  input  4  condition code to evaluate; sampled on request accept.
REQ-006 SHALL: flag_update_pending  input  1  a flag write is committing at the next clock edge.
REQ-007 SHALL: negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag  input  1 each  current status flags N, Z, C, V, M.
REQ-008 SHALL: is_bios  input  1  processor is in BIOS mode.
REQ-009 SHALL: resp_valid  output  1  result valid; held until it is consumed.
REQ-010 SHALL: resp_ready  input  1  consumer accepts the result.
REQ-011 SHALL: take  output  1  condition result; meaningful only while resp_valid is high.
REQ-012 SHALL: taken_count, skipped_count  output  16 each  statistics counters, per REQ-026.

Function
REQ-013 SHALL: the unit implements the FSM states IDLE, HAZARD, EVAL and RESP.
REQ-014 SHALL: IDLE with req_valid high:
- capture cond;
- go to HAZARD if flag_update_pending is high, otherwise go to EVAL.
REQ-015 SHALL: HAZARD lasts exactly one cycle, then goes to EVAL, regardless of flag_update_pending.
REQ-016 SHALL: EVAL samples the flags at its closing edge, registers take, sets resp_valid and goes to RESP.
REQ-017 SHALL: latency from accept edge to resp_valid is 2 edges without a hazard and 3 edges with a hazard.
REQ-018 SHALL: RESP holds resp_valid and take stable until resp_valid and resp_ready are both high at an edge, then goes to IDLE and clears resp_valid.
REQ-019 SHALL: no new request is accepted in the same cycle as the RESP handshake; throughput is at most one request per 3 cycles.
REQ-020 SHALL: the condition table is:
- 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V;
- 8 C&!Z; 9 !C|Z; 10 N==V; 11 N!=V;
- 12 !Z&(N==V); 13 Z|(N!=V); 14 always 1; 15 is_bios.
REQ-021 SHALL: mode_flag does not affect any condition, and flags are used as presented (all-ones inputs evaluate normally).
REQ-022 SHALL: flag or cond input changes during HAZARD or RESP do not alter the captured cond or the registered take.
REQ-023 SHALL: req_valid is ignored outside IDLE; the requester holds cond until accepted.

Reset
REQ-024 SHALL: reset asserted at any time, including mid-operation:
- FSM goes to IDLE immediately, without waiting for a clock edge;
- resp_valid=0, take=0, captured cond=0, taken_count=0, skipped_count=0;
- any in-flight request is dropped and no response is produced.
REQ-025 SHALL: req_ready is high in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL: macro COND_CHECK_STATS_EN controls the statistics counters.
- Defined: at each RESP handshake, taken_count increments if take=1, otherwise skipped_count increments.
- Both counters saturate at 16'hFFFF.
- Not defined: both ports are tied to 0 and no counter flops are synthesized.

Verification
REQ-027 SHALL: after reset, cond=0, Z=1, no pending update, resp_ready=1 -> resp_valid high 2 edges after accept, take=1, back in IDLE on the next edge.
REQ-028 SHALL: cond=10, N=1, V=0, flag_update_pending=1 at accept, V set to 1 during HAZARD -> resp_valid at 3 edges, take=1.
REQ-029 SHALL: cond=15, is_bios=1, resp_ready=0 for 5 cycles -> resp_valid and take=1 held for 5 cycles, req_ready=0 throughout, handshake on cycle 6.
REQ-030 SHALL: reset pulsed during EVAL -> resp_valid=0 immediately, req_ready=1 after release, no response emitted.
REQ-031 SHALL: with COND_CHECK_STATS_EN defined, 3 requests cond=14 and 2 requests cond=0 with Z=0 -> taken_count=3, skipped_count=2; without the macro, both counters read 0.
REQ-032 SHALL: exhaustive sweep of cond 0-15 against all 16 NZCV combinations -> take matches the REQ-020 table.

Source files
------------

// File: rtl/cond_check_unit.sv
// cond_check_unit: evaluates a 4-bit condition code against NZCV/BIOS flags
// with a one-cycle flag-hazard stall. Optional counters: COND_CHECK_STATS_EN.
module cond_check_unit (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  cond_i,
  input  logic        flag_update_pending_i,
  input  logic        negative_flag_i,
  input  logic        zero_flag_i,
  input  logic        carry_flag_i,
  input  logic        overflow_flag_i,
  input  logic        mode_flag_i,
  input  logic        is_bios_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        take_o,
  output logic [15:0] taken_count_o,
  output logic [15:0] skipped_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HAZARD,
    S_EVAL,
    S_RESP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cond_q, cond_d;
  logic       take_q, take_d;
  logic       resp_valid_q, resp_valid_d;
  logic       cond_hit;
  logic       hs;

  // M never participates in any condition
  logic unused_mode;
  assign unused_mode = mode_flag_i;

  // condition table on the captured code and live flags
  always_comb begin
    cond_hit = 1'b0;
    unique case (cond_q)
      4'd0:  cond_hit = zero_flag_i;
      4'd1:  cond_hit = !zero_flag_i;
      4'd2:  cond_hit = carry_flag_i;
      4'd3:  cond_hit = !carry_flag_i;
      4'd4:  cond_hit = negative_flag_i;
      4'd5:  cond_hit = !negative_flag_i;
      4'd6:  cond_hit = overflow_flag_i;
      4'd7:  cond_hit = !overflow_flag_i;
      4'd8:  cond_hit = carry_flag_i & !zero_flag_i;
      4'd9:  cond_hit = !carry_flag_i | zero_flag_i;
      4'd10: cond_hit = negative_flag_i == overflow_flag_i;
      4'd11: cond_hit = negative_flag_i != overflow_flag_i;
      4'd12: cond_hit = !zero_flag_i &
                        (negative_flag_i == overflow_flag_i);
      4'd13: cond_hit = zero_flag_i |
                        (negative_flag_i != overflow_flag_i);
      4'd14: cond_hit = 1'b1;
      4'd15: cond_hit = is_bios_i;
      default: cond_hit = 1'b0;
    endcase
  end

  // next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    cond_d       = cond_q;
    take_d       = take_q;
    resp_valid_d = resp_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          cond_d  = cond_i;
          state_d = flag_update_pending_i ? S_HAZARD : S_EVAL;
        end
      end
      S_HAZARD: state_d = S_EVAL;
      S_EVAL: begin
        take_d       = cond_hit;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and result registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cond_q       <= 4'd0;
      take_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cond_q       <= cond_d;
      take_q       <= take_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign hs           = (state_q == S_RESP) & resp_ready_i;
  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign take_o       = take_q;

`ifdef COND_CHECK_STATS_EN
  logic [15:0] taken_q, skipped_q;

  // saturating per-handshake outcome counters
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      taken_q   <= 16'd0;
      skipped_q <= 16'd0;
    end else if (hs) begin
      if (take_q) begin
        if (taken_q != 16'hFFFF) taken_q <= taken_q + 16'd1;
      end else begin
        if (skipped_q != 16'hFFFF) skipped_q <= skipped_q + 16'd1;
      end
    end
  end

  assign taken_count_o   = taken_q;
  assign skipped_count_o = skipped_q;
`else
  logic unused_hs;
  assign unused_hs       = hs;
  assign taken_count_o   = 16'd0;
  assign skipped_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_cond_check_unit.sv
// tb_cond_check_unit: directed checks of cond_check_unit latency,
// hazard stall, backpressure, async reset, counters and the full table.
module tb_cond_check_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  cond;
  logic        pend;
  logic        fn, fz, fc, fv, fm;
  logic        bios;
  logic        resp_valid;
  logic        resp_ready;
  logic        take;
  logic [15:0] taken_cnt, skipped_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cond_check_unit dut (
    .clock_i               (clk),
    .reset_i               (rst),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .cond_i                (cond),
    .flag_update_pending_i (pend),
    .negative_flag_i       (fn),
    .zero_flag_i           (fz),
    .carry_flag_i          (fc),
    .overflow_flag_i       (fv),
    .mode_flag_i           (fm),
    .is_bios_i             (bios),
    .resp_valid_o          (resp_valid),
    .resp_ready_i          (resp_ready),
    .take_o                (take),
    .taken_count_o         (taken_cnt),
    .skipped_count_o       (skipped_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model(input logic [3:0] c,
                                 input logic n, z, cy, v, b);
    logic ge;
    ge = ~(n ^ v);
    case (c)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return cy;
      4'd3:  return ~cy;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return ge;
      4'd11: return ~ge;
      4'd12: return ge && !z;
      4'd13: return !(ge && !z);
      4'd14: return 1'b1;
      default: return b;
    endcase
  endfunction

  // issue one request, wait bounded for the response, then consume it
  task automatic issue(input logic [3:0] c, input logic p,
                       output int lat, output logic tk);
    req_valid = 1'b1;
    cond      = c;
    pend      = p;
    tick();
    req_valid = 1'b0;
    pend      = 1'b0;
    lat       = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    tk = take;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    logic tk;
    rst = 1'b1; req_valid = 0; cond = 0; pend = 0;
    fn = 0; fz = 0; fc = 0; fv = 0; fm = 0; bios = 0;
    resp_ready = 0;
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_take", take, 0);
    check("rst_taken_cnt", taken_cnt, 0);
    check("rst_skipped_cnt", skipped_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1);

    // no-hazard request, consumer always ready
    fz = 1; resp_ready = 1;
    req_valid = 1; cond = 4'd0;
    tick();
    req_valid = 0;
    check("nh_edge1_valid", resp_valid, 0);
    check("nh_edge1_ready", req_ready, 0);
    tick();
    check("nh_edge2_valid", resp_valid, 1);
    check("nh_edge2_take", take, 1);
    tick();
    check("nh_back_idle", req_ready, 1);
    check("nh_valid_clr", resp_valid, 0);
    resp_ready = 0;

    // hazard stall; V changes during the HAZARD cycle
    fz = 0; fn = 1; fv = 0;
    req_valid = 1; cond = 4'd10; pend = 1;
    tick();
    req_valid = 0; pend = 0;
    fv = 1;
    check("hz_edge1_valid", resp_valid, 0);
    tick();
    check("hz_edge2_valid", resp_valid, 0);
    tick();
    check("hz_edge3_valid", resp_valid, 1);
    check("hz_take", take, 1);
    resp_ready = 1;
    tick();
    resp_ready = 0;
    fn = 0; fv = 0;

    // backpressure: result must hold while inputs wiggle
    bios = 1;
    issue_hold: begin
      req_valid = 1; cond = 4'd15;
      tick();
      req_valid = 0;
      tick();
      bios = 0; cond = 4'd0; fz = 0; req_valid = 1;
      for (int i = 0; i < 5; i++) begin
        check("bp_valid_held", resp_valid, 1);
        check("bp_take_held", take, 1);
        check("bp_ready_low", req_ready, 0);
        tick();
      end
      req_valid = 0;
      resp_ready = 1;
      tick();
      resp_ready = 0;
      check("bp_hs_clr", resp_valid, 0);
      check("bp_hs_idle", req_ready, 1);
    end

    // async reset during EVAL and during RESP
    fz = 1;
    req_valid = 1; cond = 4'd0;
    tick();
    req_valid = 0;
    rst = 1;
    #1;
    check("rst_eval_valid", resp_valid, 0);
    check("rst_eval_ready", req_ready, 1);
    tick();
    rst = 0;
    tick();
    check("rst_eval_after_ready", req_ready, 1);
    check("rst_eval_no_resp", resp_valid, 0);
    tick();
    check("rst_eval_no_resp2", resp_valid, 0);
    req_valid = 1; cond = 4'd0;
    tick();
    req_valid = 0;
    tick();
    check("rst_resp_pre", resp_valid, 1);
    #2 rst = 1;
    #1;
    check("rst_resp_async_valid", resp_valid, 0);
    check("rst_resp_async_take", take, 0);
    check("rst_resp_async_ready", req_ready, 1);
    tick();
    rst = 0;
    tick();

    // statistics: 3 taken, 2 skipped
    fz = 0;
    for (int i = 0; i < 3; i++) issue(4'd14, 1'b0, lat, tk);
    for (int i = 0; i < 2; i++) issue(4'd0, 1'b0, lat, tk);
`ifdef COND_CHECK_STATS_EN
    check("stats_taken", taken_cnt, 3);
    check("stats_skipped", skipped_cnt, 2);
`else
    check("stats_taken_off", taken_cnt, 0);
    check("stats_skipped_off", skipped_cnt, 0);
`endif

    // full table sweep, M toggled, alternating hazard
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic [3:0] fl;
        logic       exp;
        fl = 4'(f);
        fn = fl[3]; fz = fl[2]; fc = fl[1]; fv = fl[0];
        fm = fl[0] ^ fl[3];
        bios = 1'(c & 1) ^ fl[1];
        exp = model(4'(c), fn, fz, fc, fv, bios);
        issue(4'(c), 1'(f & 1), lat, tk);
        if (lat >= 10) check("sweep_timeout", lat, (f & 1) ? 3 : 2);
        check($sformatf("sweep_c%0d_f%0h", c, f), tk, exp);
      end
    end
    fm = 1;
    issue(4'd14, 1'b1, lat, tk);
    check("lat_hazard", lat, 3);
    issue(4'd14, 1'b0, lat, tk);
    check("lat_plain", lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
